// File: rtl/lfsr_scramble_serializer.sv
// LFSR scrambler feeding an LSB-first serializer with valid/ready back-pressure.
// Define LFSR_PARITY_EN to append an even-parity beat after each word.
module lfsr_scramble_serializer #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAPS        = 8'b0001_1101,
  parameter int               LFSR_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Seed,
  input  logic             Start,
  input  logic             Ready,
  output logic             OUT,
  output logic             Valid,
  output logic             Busy,
  output logic             Done,
  output logic             Parity_Flag
);

  localparam int CW = (LFSR_CYCLES > 0) ?
    $clog2(LFSR_CYCLES + 1) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE, SCRAMBLE, SHIFT, PARITY
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] lfsr, lfsr_n;
  logic [CW-1:0]    ccnt, ccnt_n;
  logic [BW-1:0]    bcnt, bcnt_n;
  logic             done_n;
  logic             accept;
  logic             fb;
  logic [WIDTH-1:0] load;

  assign accept = Valid && Ready;
  assign fb     = ^(lfsr & TAPS);
  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  assign load   = (Seed == '0) ? WIDTH'(1) : Seed;
  assign Busy   = (state != IDLE);

  // Next-state, next-register and counter logic.
  always_comb begin
    state_n = state;
    lfsr_n  = lfsr;
    ccnt_n  = ccnt;
    bcnt_n  = bcnt;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          lfsr_n  = load;
          ccnt_n  = '0;
          bcnt_n  = '0;
          state_n = (LFSR_CYCLES == 0) ?
            SHIFT : SCRAMBLE;
        end
      end
      SCRAMBLE: begin
        lfsr_n = {fb, lfsr[WIDTH-1:1]};
        ccnt_n = ccnt + 1'b1;
        if (ccnt == CW'(LFSR_CYCLES - 1)) begin
          state_n = SHIFT;
          bcnt_n  = '0;
        end
      end
      SHIFT: begin
        if (accept) begin
          lfsr_n = {1'b0, lfsr[WIDTH-1:1]};
          bcnt_n = bcnt + 1'b1;
          if (bcnt == BW'(WIDTH - 1)) begin
`ifdef LFSR_PARITY_EN
            state_n = PARITY;
`else
            state_n = IDLE;
            done_n  = 1'b1;
`endif
          end
        end
      end
      PARITY: begin
        if (accept) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
    endcase
  end

  // State, shift register, counters and the registered Done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      lfsr  <= '0;
      ccnt  <= '0;
      bcnt  <= '0;
      Done  <= 1'b0;
    end else begin
      state <= state_n;
      lfsr  <= lfsr_n;
      ccnt  <= ccnt_n;
      bcnt  <= bcnt_n;
      Done  <= done_n;
    end
  end

`ifdef LFSR_PARITY_EN
  logic par;

  // Latch parity of the finished scrambled word on SHIFT entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par <= 1'b0;
    end else if (state != SHIFT &&
                 state_n == SHIFT) begin
      par <= ^lfsr_n;
    end
  end

  assign Valid       = (state == SHIFT) ||
                       (state == PARITY);
  assign OUT         = (state == SHIFT) ? lfsr[0] :
                       ((state == PARITY) & par);
  assign Parity_Flag = (state == PARITY);
`else
  assign Valid       = (state == SHIFT);
  assign OUT         = Valid & lfsr[0];
  assign Parity_Flag = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_scramble_serializer.sv
// Bench for lfsr_scramble_serializer: three configurations
// checked against a word-level reference model.
module tb_lfsr_scramble_serializer;

  localparam int        WD [3] = '{4, 8, 4};
  localparam int        LC [3] = '{2, 8, 0};
  localparam logic [7:0] TP [3] = '{8'h03, 8'h1d, 8'h03};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] seed [3];
  logic [2:0] start = '0;
  logic [2:0] ready = '0;
  wire  [2:0] outb, valid, busy, done, pflag;

  int total = 0;
  int bad   = 0;
  bit expq [$];

  always #5 clk = ~clk;

  lfsr_scramble_serializer #(
    .WIDTH(4), .TAPS(4'b0011), .LFSR_CYCLES(2)
  ) u0 (
    .clk(clk), .rst(rst), .Seed(seed[0][3:0]),
    .Start(start[0]), .Ready(ready[0]),
    .OUT(outb[0]), .Valid(valid[0]), .Busy(busy[0]),
    .Done(done[0]), .Parity_Flag(pflag[0])
  );

  lfsr_scramble_serializer u1 (
    .clk(clk), .rst(rst), .Seed(seed[1]),
    .Start(start[1]), .Ready(ready[1]),
    .OUT(outb[1]), .Valid(valid[1]), .Busy(busy[1]),
    .Done(done[1]), .Parity_Flag(pflag[1])
  );

  lfsr_scramble_serializer #(
    .WIDTH(4), .TAPS(4'b0011), .LFSR_CYCLES(0)
  ) u2 (
    .clk(clk), .rst(rst), .Seed(seed[2][3:0]),
    .Start(start[2]), .Ready(ready[2]),
    .OUT(outb[2]), .Valid(valid[2]), .Busy(busy[2]),
    .Done(done[2]), .Parity_Flag(pflag[2])
  );

  // Word-level model: expected serial beats for one seed.
  function automatic void model(input int d,
                                input logic [7:0] sd);
    int w, v, fb;
    w = WD[d];
    v = int'(sd) & ((1 << w) - 1);
    if (v == 0) v = 1;
    for (int k = 0; k < LC[d]; k++) begin
      fb = $countones(v & int'(TP[d])) % 2;
      v  = (v >> 1) | (fb << (w - 1));
    end
    expq.delete();
    for (int k = 0; k < w; k++)
      expq.push_back(((v >> k) & 1) == 1);
`ifdef LFSR_PARITY_EN
    expq.push_back(($countones(v) % 2) == 1);
`endif
  endfunction

  task automatic run_word(input int d,
                          input logic [7:0] sd,
                          input int rmode,
                          input bit noise,
                          input bit pre,
                          input bit chain,
                          input logic [7:0] nxt);
    int n, i, stall, cyc;
    bit r;
    logic [4:0] o, e;
    n = expq.size();
    if (!pre) begin
      @(negedge clk);
      seed[d]  = sd;
      start[d] = 1'b1;
      ready[d] = 1'b0;
    end
    @(negedge clk);
    start[d] = 1'b0;
    if (noise) seed[d] = 8'($urandom);
    for (int c = 0; c < LC[d]; c++) begin
      o = {valid[d], outb[d], pflag[d], busy[d], done[d]};
      e = 5'b00010;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL scramble d%0d c%0d got=%b want=%b",
                 d, c, o, e);
      end
      if (noise) begin
        start[d] = 1'($urandom);
        ready[d] = 1'($urandom);
      end
      @(negedge clk);
    end
    i = 0; cyc = 0; stall = 0;
    while (i < n && cyc < 300) begin
      o = {valid[d], outb[d], pflag[d], busy[d], done[d]};
      e = {1'b1, expq[i], (i == WD[d]), 1'b1, 1'b0};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL beat d%0d i%0d got=%b want=%b",
                 d, i, o, e);
      end
      case (rmode)
        0: r = 1'b1;
        1: r = 1'($urandom);
        default: begin
          r = !(i == 1 && stall < 3);
          if (!r) stall++;
        end
      endcase
      ready[d] = r;
      if (noise) begin
        start[d] = 1'($urandom);
        seed[d]  = 8'($urandom);
      end
      @(negedge clk);
      cyc++;
      if (r) i++;
    end
    if (i < n) begin
      total++; bad++;
      $display("FAIL timeout d%0d beats=%0d want=%0d",
               d, i, n);
    end
    start[d] = 1'b0;
    ready[d] = 1'b0;
    o = {valid[d], outb[d], pflag[d], busy[d], done[d]};
    e = 5'b00001;
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL done d%0d got=%b want=%b", d, o, e);
    end
    if (chain) begin
      seed[d]  = nxt;
      start[d] = 1'b1;
    end else begin
      @(negedge clk);
      o = {valid[d], outb[d], pflag[d], busy[d], done[d]};
      total++;
      if (o !== 5'b0) begin
        bad++;
        $display("FAIL idle d%0d got=%b want=00000", d, o);
      end
    end
  endtask

  task automatic test_reset();
    logic [4:0] o;
    for (int d = 0; d < 3; d++) seed[d] = '0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      o = {valid[d], outb[d], pflag[d], busy[d], done[d]};
      total++;
      if (o !== 5'b0) begin
        bad++;
        $display("FAIL reset d%0d got=%b want=00000", d, o);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_abort();
    logic [4:0] o;
    @(negedge clk);
    seed[0] = 8'h09; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; ready[0] = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (valid[0] !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre got=%b want=1", valid[0]);
    end
    #2 rst = 1'b0;
    #1;
    o = {valid[0], outb[0], pflag[0], busy[0], done[0]};
    total++;
    if (o !== 5'b0) begin
      bad++;
      $display("FAIL abort_async got=%b want=00000", o);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      o = {valid[0], outb[0], pflag[0], busy[0], done[0]};
      total++;
      if (o !== 5'b0) begin
        bad++;
        $display("FAIL abort_after c%0d got=%b want=00000",
                 c, o);
      end
    end
    ready[0] = 1'b0;
    model(0, 8'h05);
    run_word(0, 8'h05, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_directed();
    expq = '{1'b0, 1'b1, 1'b1, 1'b0};
`ifdef LFSR_PARITY_EN
    expq.push_back(1'b0);
`endif
    run_word(0, 8'h09, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_stall();
    expq = '{1'b0, 1'b1, 1'b1, 1'b0};
`ifdef LFSR_PARITY_EN
    expq.push_back(1'b0);
`endif
    run_word(0, 8'h09, 2, 1, 0, 0, 8'h00);
  endtask

  task automatic test_zero_seed();
    model(1, 8'h01);
    run_word(1, 8'h00, 0, 0, 0, 0, 8'h00);
    model(1, 8'h01);
    run_word(1, 8'h01, 1, 0, 0, 0, 8'h00);
  endtask

  task automatic test_no_scramble();
    expq = '{1'b0, 1'b1, 1'b0, 1'b1};
`ifdef LFSR_PARITY_EN
    expq.push_back(1'b0);
`endif
    run_word(2, 8'h0A, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] s1, s2;
    for (int d = 0; d < 3; d += 2) begin
      s1 = 8'($urandom);
      s2 = 8'($urandom);
      model(d, s1);
      run_word(d, s1, 0, 0, 0, 1, s2);
      model(d, s2);
      run_word(d, s2, 1, 0, 1, 0, 8'h00);
    end
  endtask

  task automatic test_random();
    int d;
    logic [7:0] sd;
    for (int k = 0; k < 24; k++) begin
      d  = int'($urandom_range(0, 2));
      sd = 8'($urandom);
      if (k % 6 == 0) sd = 8'h00;
      model(d, sd);
      run_word(d, sd, 1, 1, 0, 0, 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_abort();
    test_directed();
    test_stall();
    test_zero_seed();
    test_no_scramble();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
